// File: rtl/hist_level_decoder_pkg.sv
// Shared definitions for the histogram level decoder and related debug probes.
package hist_level_decoder_pkg;

    // Largest supported sample width (32 bins).
    localparam int unsigned MaxWidth = 5;

    // FSM state encoding, kept as plain constants for legacy tools.
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StRun    = 2'd2;

    // Map a sample onto a bin index. Signed samples are converted to offset
    // binary (MSB inverted) so the most negative value lands in bin 0.
    function automatic logic [MaxWidth-1:0] bin_index(
        input logic [MaxWidth-1:0] sample,
        input int unsigned         width,
        input bit                  is_signed
    );
        logic [MaxWidth-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            if (i < width) begin
                idx[i] = (is_signed && (i == width - 1)) ? ~sample[i] : sample[i];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hist_level_decoder_onehot_decoder.sv
// Registered index-to-one-hot decoder with enable; zero output when disabled.
module onehot_decoder #(
    parameter int unsigned WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic [WIDTH-1:0]      index,
    output logic [2**WIDTH-1:0]   lines,
    output logic                  valid
);

    localparam int unsigned Lines = 2 ** WIDTH;

    logic [Lines-1:0] lines_q;
    logic             valid_q;

    // Output register; async clear so no stale bin survives a reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lines_q <= '0;
            valid_q <= 1'b0;
        end else begin
            lines_q <= en ? (Lines'(1) << index) : '0;
            valid_q <= en;
        end
    end

    assign lines = lines_q;
    assign valid = valid_q;

endmodule

// File: rtl/hist_level_decoder.sv
// Converts a sample stream into one-hot amplitude-bin strobes for the
// histogram counter bank, with enable gating, settle hold-off and decimation.
module hist_level_decoder
    import hist_level_decoder_pkg::*;
#(
    parameter int unsigned  WIDTH  = 3,
    parameter bit           SIGNED = 1'b1,
    parameter int unsigned  SETTLE = 4,
    localparam int unsigned LINES  = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [7:0]       decim,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic [LINES-1:0] out_lines,
    output logic             out_valid,
    output logic             running
);

    localparam int unsigned SettleW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    if (WIDTH < 1 || WIDTH > MaxWidth) begin : g_bad_width
        $error("hist_level_decoder: WIDTH must be 1..%0d", MaxWidth);
    end
    if (SETTLE < 1) begin : g_bad_settle
        $error("hist_level_decoder: SETTLE must be at least 1");
    end

    logic [1:0]         state_q, state_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [7:0]         dcnt_q, dcnt_d;
    logic               accept;
    logic               acc_q;
    logic [WIDTH-1:0]   idx_d, idx_q;
    logic               running_q;

    assign idx_d = WIDTH'(bin_index(MaxWidth'(in_data), WIDTH, SIGNED));

    // Enable / settle state machine; any cycle with en low returns to idle.
    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        case (state_q)
            StIdle: begin
                if (en) state_d = StSettle;
            end
            StSettle: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (settle_q == SettleW'(SETTLE - 1)) begin
                    state_d = StRun;
                end else begin
                    settle_d = settle_q + SettleW'(1);
                end
            end
            StRun: begin
                if (!en) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Decimation: accept when the count has reached (or passed) decim, so a
    // mid-run decrease of decim can never leave the counter running away.
    always_comb begin
        accept = 1'b0;
        dcnt_d = '0;
        if (state_q == StRun) begin
            dcnt_d = dcnt_q;
            if (in_valid) begin
                if (dcnt_q >= decim) begin
                    accept = 1'b1;
                    dcnt_d = '0;
                end else begin
                    dcnt_d = dcnt_q + 8'd1;
                end
            end
        end
    end

    // Control state, counters and pipeline stage 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            settle_q  <= '0;
            dcnt_q    <= '0;
            acc_q     <= 1'b0;
            idx_q     <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            dcnt_q    <= dcnt_d;
            acc_q     <= accept;
            idx_q     <= idx_d;
            running_q <= (state_d == StRun);
        end
    end

    // Pipeline stage 2: registered one-hot expansion.
    onehot_decoder #(
        .WIDTH (WIDTH)
    ) u_onehot (
        .clk    (clk),
        .resetn (resetn),
        .en     (acc_q),
        .index  (idx_q),
        .lines  (out_lines),
        .valid  (out_valid)
    );

    assign running = running_q;

endmodule

// File: doc/hist_level_decoder.md
Name: hist_level_decoder

Overview:
- Upstream feeder for the debug histogram counter bank.
- Converts a multi-bit ADC/baseband sample stream into one-hot amplitude-bin lines, at most one line high per clock.
- The downstream counter counts high cycles per line, so its result registers read out amplitude-level occupancy over each 2^16-cycle window.
- Adds enable gating, settle hold-off and runtime decimation so the occupancy statistic is not biased by idle cycles or by start-up transients.

Parameters:
- WIDTH, 3, sample width in bits; number of bins LINES = 2**WIDTH is a derived localparam (max WIDTH = 5).
- SIGNED, 1, 1 = two's-complement input, 0 = unsigned input.
- SETTLE, 4, clocks of qualified enable required before bins are emitted (>=1).

Ports:
- clk, input, 1, sample/data clock (same domain as the downstream counter clock).
- resetn, input, 1, asynchronous active-low reset.
- en, input, 1, level enable; low forces idle.
- decim, input, 8, keep one accepted sample out of (decim+1) valid samples; quasi-static.
- in_valid, input, 1, sample strobe.
- in_data, input, WIDTH, sample value.
- out_lines, output, LINES, one-hot bin lines, drives the downstream counter data input.
- out_valid, output, 1, OR of out_lines (registered).
- running, output, 1, high in RUN state.

Behaviour:
- Reset: clk clock, resetn reset, asynchronous, active-low. All registers clear: state = IDLE, settle counter = 0, decimation counter = 0, pipeline = 0. out_lines = 0, out_valid = 0, running = 0.
- FSM states, encoding: IDLE = 0, SETTLE = 1, RUN = 2.
- IDLE -> SETTLE when en = 1.
- SETTLE: the settle counter increments every clock.
  - Go to RUN when the counter = SETTLE-1 and en is still 1.
  - en = 0 -> IDLE, counter cleared.
- RUN -> IDLE when en = 0. Any state with en = 0 goes to IDLE on the next edge.
- running is a registered decode of state == RUN.
- Decimation:
  - Active only in RUN. The decimation counter is cleared on entry to RUN and in every non-RUN state.
  - On in_valid in RUN: if the counter == decim, the sample is accepted and the counter returns to 0; otherwise the counter increments.
  - decim = 0 accepts every valid sample. decim = 255 accepts 1 in 256.
  - A change of decim mid-run takes effect at the next comparison. If the counter is already greater than the new decim, the sample is accepted and the counter wraps to 0; the counter must never run away.
- Bin mapping:
  - SIGNED = 1: index = {~in_data[MSB], in_data[MSB-1:0]} (offset binary). The most negative value maps to line 0, the most positive to line LINES-1. For WIDTH = 3: -4 -> 0, -1 -> 3, 0 -> 4, +3 -> 7.
  - SIGNED = 0: index = in_data.
- Pipeline, fixed latency 2:
  - Stage 1 registers accept and index.
  - Stage 2 registers out_lines = accept ? (1 << index) : 0, and out_valid = accept.
  - An accepted sample at edge N appears on out_lines after edge N+2, for exactly 1 clock.
- Invariants:
  - out_lines is zero or exactly one-hot every cycle.
  - Back-to-back accepted samples produce back-to-back one-hot cycles.
- en falling mid-pipeline: samples already accepted in stage 1 still drain normally (no truncation); nothing new is accepted after the first IDLE cycle.
- in_valid while not in RUN is ignored and produces no output.
- in_data is don't-care when in_valid = 0.
- Reset mid-operation clears the pipeline immediately (asynchronous); out_lines = 0 with no glitch to a stale bin.

Decomposition:
- Shared debug package holds:
  - the FSM state constants;
  - the offset-binary mapping function (index from sample, SIGNED);
  - the max WIDTH check constant.
- One natural sub-module: onehot_decoder (registered index-to-one-hot with enable, parameter WIDTH), reusable by other debug probes.
- Everything else stays in the top.

Test Plan:
- Reset/idle: resetn low then high with en = 0 and in_valid = 1 for 100 clocks -> out_lines = 0 and running = 0 throughout.
- Settle: en rises at cycle 0, SETTLE = 4, in_valid = 1 continuously -> running high after 5 edges; first non-zero out_lines exactly 2 clocks after the first accepted sample; no output before.
- Mapping, WIDTH = 3, SIGNED = 1, decim = 0: feed -4, -1, 0, 3 on consecutive clocks -> out_lines = 0x01, 0x08, 0x10, 0x80 on consecutive clocks; out_valid = 1 for each.
- Decimation: decim = 3, in_valid = 1 every clock for 16 clocks in RUN -> exactly 4 one-hot pulses, spaced 4 clocks apart. decim switched 5 -> 1 while the counter = 4 -> next valid sample accepted and the counter returns to 0.
- en drop: en = 0 one clock after an accepted sample -> that sample still appears 2 clocks later; zero output afterwards; running low next clock.
- Async reset mid-run: resetn pulled low between edges while out_lines = 0x20 -> out_lines = 0 immediately; after release, SETTLE hold-off repeats before any output.
